// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with occupancy count, watermarks and flush.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags (cleared by err_clr).
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0] AF_WORD = AF_LEVEL;
  localparam logic [31:0] AE_WORD = AE_LEVEL;
  localparam logic [ADDR_W:0] AF_CNT = AF_WORD[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT = AE_WORD[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Storage is deliberately unreset; the head word is read combinationally.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flags decode only the registered count, never the request inputs.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // A set condition in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en & full & ~flush) begin
        overflow_q <= 1'b1;
      end else if (err_clr) begin
        overflow_q <= 1'b0;
      end
      if (rd_en & empty & ~flush) begin
        underflow_q <= 1'b1;
      end else if (err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next-generation buffer for byte and word streams between producer/consumer blocks in the datapath. Generalises the 32×8 FIFO with configurable width and depth, an occupancy output, programmable almost-full/almost-empty watermarks, and a synchronous flush. Optional sticky overflow/underflow error flags are compiled in by macro. Read data is show-ahead: the head word is always presented on `dout`.

## Interface
- `DATA_W`, default 8: data width in bits, ≥1.
- `ADDR_W`, default 5: pointer width; depth `DEPTH = 2**ADDR_W`, ADDR_W ≥ 1.
- `AF_LEVEL`, default `DEPTH-2`: `almost_full` asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- `AE_LEVEL`, default 2: `almost_empty` asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of pointers and count.
- `wr_en` in 1: write request.
- `din` in DATA_W: write data.
- `rd_en` in 1: read (pop) request.
- `dout` out DATA_W: head-of-queue data, combinational from `mem[rd_ptr]`.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: watermark flag.
- `almost_empty` out 1: watermark flag.
- `count` out ADDR_W+1: current occupancy, 0..DEPTH.
- `err_clr` in 1: clears sticky error flags.
- `overflow` out 1: sticky, write attempted while full.
- `underflow` out 1: sticky, read attempted while empty.

## Operation
- Write accepted (`wr_acc`) = `wr_en & !full & !flush`; `din` stored at `wr_ptr`, `wr_ptr` increments mod DEPTH.
- Read accepted (`rd_acc`) = `rd_en & !empty & !flush`; `rd_ptr` increments mod DEPTH.
- Count: `+1` on wr_acc only, `-1` on rd_acc only, unchanged on both or neither. Count is registered and ADDR_W+1 bits wide, so it never wraps.
- Both requests while full: the read is accepted and the write is dropped; count goes DEPTH→DEPTH-1.
- Both requests while empty: the write is accepted and the read is dropped; count goes 0→1.
- Pointers wrap naturally at 2**ADDR_W. Full and empty are decoded from count, never from pointer equality.
- `flush` has priority over wr/rd. The next edge sets `rd_ptr = wr_ptr = count = 0`. Memory contents are not cleared, and a write in the flush cycle is discarded.
- All flags are combinational decodes of the registered count, so they are glitch-free relative to `clk`.
- Memory has no reset. `dout` after reset or flush is don't-care until the first write.
- Error flags: `overflow` sets on `wr_en & full & !flush`, and `underflow` sets on `rd_en & empty & !flush`. Both hold until an `err_clr` edge or reset. If a set condition and `err_clr` occur in the same cycle, the set wins.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - overflow = underflow = 0
  - pointers = 0
- Write latency: data written at edge N appears on `dout` after edge N if the FIFO was empty. `empty` deasserts in the same cycle.
- Read: `dout` is valid while `!empty`. Asserting `rd_en` pops at the edge, and the next word appears after that edge.
- Flags and count update one edge after the accepted operation. There is no combinational path from `wr_en`/`rd_en` to the flags.
- Reset asserted mid-operation clears all registers immediately (asynchronously). Deassertion is assumed synchronised upstream.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - sticky `overflow`/`underflow` logic and `err_clr` are implemented as described above.
- Not defined:
  - `overflow` and `underflow` are tied to 0.
  - `err_clr` is ignored.
  - Ports remain present so instantiations are unchanged.
  - FIFO data behaviour is identical in both builds.

## Test plan
- Reset, then write 0x01..0x20 with DATA_W=8, ADDR_W=5 -> full=1 after the 32nd edge and count=32. `almost_full` first asserts at count=30.
- Full FIFO, write 0xAA -> count stays 32, data is not stored, and overflow=1 (with the macro) or 0 (without). `err_clr` then returns overflow to 0.
- Drain all 32 words -> `dout` sequence 0x01..0x20, empty=1. Reading once more sets underflow=1 and leaves count=0.
- Count=32 with `wr_en` and `rd_en` together -> count=31, head advances, and the written word is dropped. At count=0 with both -> count=1 and `dout` equals the written word.
- Fill 40 then drain 40 interleaved with fill 10/drain 10 -> pointer wrap-around preserves order.
- Count=5, assert `flush` with `wr_en` -> count=0 and empty=1 next edge. Asserting `rst` low mid-burst -> outputs immediately take their reset values.
